serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two-operand subtractor: D = A - B, one bit per clock, LSB first.
//  Inverse arithmetic companion of the ripple adders in the arithmetic examples.
//  Multi-cycle start/done handshake. Sits beside them as the area-minimal
//  datapath for subtraction and compare.
// PARAMETERS
//  WIDTH  4  operand and result width in bits (>= 2)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only when busy=0
//  A       in   WIDTH  minuend; captured on the accepting edge
//  B       in   WIDTH  subtrahend; captured on the accepting edge
//  busy    out  1      high while an operation is in progress
//  done    out  1      one-cycle completion pulse
//  D       out  WIDTH  difference; held from done until next completion
//  borrow  out  1      final borrow (1 = A < B unsigned); held like D
// BEHAVIOUR
//  - Clocking and reset: one clock, clk. rst_n is asynchronous and active-low;
//    asserting it forces every register to reset at once, from any state.
//  - Reset values: busy=0, done=0, D=0, borrow=0, state=IDLE, bit count=0,
//    internal borrow=0, operand shift registers=0.
//  - State machine: IDLE -> RUN -> IDLE. Only these two states are used.
//  - IDLE: when start=1 at an edge:
//    - latch A and B into shift registers;
//    - set count=0 and internal borrow br=0;
//    - set busy=1 and go to RUN.
//  - RUN, every edge, with a0/b0 = current LSBs:
//    - d   = a0 ^ b0 ^ br
//    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
//    - shift both operands right by 1;
//    - shift d into the MSB of the result shift register;
//    - count increments.
//  - Completion edge (count = WIDTH-1):
//    - D <= final result register, including the bit shifted in on this edge;
//    - borrow <= br';
//    - done <= 1, busy <= 0; go to IDLE.
//  - Latency: done is visible exactly WIDTH edges after the start-accepting
//    edge. Throughput is one operation per WIDTH+1 cycles back-to-back.
//  - done is high for exactly one cycle and is cleared on the next edge.
//  - start while busy=1 is ignored; there is no queueing.
//  - start while done=1 is accepted, because busy is already 0 in that cycle.
//  - Same-edge events: if an edge both sees done=1 and accepts a new start, on
//    that edge done drops to 0 and busy rises to 1. D and borrow keep the
//    previous result until the new completion.
//  - Result width: D is WIDTH bits, modulo 2^WIDTH (two's-complement wrap).
//    The borrow-out is reported only on the borrow output.
//  - D and borrow never change mid-operation; only the completion edge
//    updates them.
//  - Reset during RUN aborts the operation: done is never pulsed for it, and
//    D and borrow read 0.
// CONFIGURATION
//  - Macro SUB_SATURATE_EN.
//  - Defined: on a completion edge where borrow'=1, D is forced to 0
//    (unsigned floor saturation). borrow is still reported as 1.
//  - Not defined: D always carries the wrapped modulo-2^WIDTH difference.
//  - Latency and handshake are identical in both builds.
// TESTING  (WIDTH=4 unless noted)
//  1. A=9, B=3, start one cycle -> busy for 4 edges, done pulse with D=6,
//     borrow=0; done low on the following cycle.
//  2. A=3, B=5 -> D=4'hE, borrow=1. With SUB_SATURATE_EN defined: D=0,
//     borrow=1.
//  3. A=15, B=15 -> D=0, borrow=0. Then A=0, B=1 -> D=4'hF, borrow=1
//     (4'h0 with SUB_SATURATE_EN).
//  4. A=7, B=2 started; start held high with A=1, B=1 during RUN -> only one
//     completion, D=5. Next op starts on the done cycle: A=1, B=1 -> D=0
//     exactly 4 edges later.
//  5. A=12, B=4 started; rst_n low after 2 RUN edges -> busy, done, D and
//     borrow all 0 immediately. No done pulse follows; after release, a new
//     op A=12, B=4 gives D=8.
//  6. WIDTH=8: A=8'h80, B=8'h01 -> D=8'h7F, borrow=0, done exactly 8 edges
//     after start.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             borrow;

    modport master (
        output start, A, B,
        input  busy, done, D, borrow
    );

    modport slave (
        input  start, A, B,
        output busy, done, D, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B, LSB first, one bit per clock, start/done handshake.
// Optional macro SUB_SATURATE_EN clamps D to 0 on a final borrow (unsigned floor).
//
// state | meaning
// IDLE  | waiting for start; D/borrow hold the last result
// RUN   | shifting one bit per edge; completes when count = WIDTH-1
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave sif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_nxt = {d_bit, res_q[WIDTH-1:1]};

        state_d  = state_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sif.start) begin
                    a_d     = sif.A;
                    b_d     = sif.B;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_nxt;
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef SUB_SATURATE_EN
                    diff_d = br_nxt ? '0 : res_nxt;
`else
                    diff_d = res_nxt;
`endif
                    borrow_d = br_nxt;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sif.busy   = busy_q;
    assign sif.done   = done_q;
    assign sif.D      = diff_q;
    assign sif.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=4 handshake/arith cases plus a WIDTH=8 run.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

`ifdef SUB_SATURATE_EN
    localparam logic [3:0] EXP_3_5 = 4'h0;
    localparam logic [3:0] EXP_0_1 = 4'h0;
`else
    localparam logic [3:0] EXP_3_5 = 4'hE;
    localparam logic [3:0] EXP_0_1 = 4'hF;
`endif

    serial_subtractor_if #(.WIDTH(4)) s4 ();
    serial_subtractor_if #(.WIDTH(8)) s8 ();

    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .sif(s4));
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .sif(s8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_d, input logic exp_br);
        int lat;
        s4.A     = a;
        s4.B     = b;
        s4.start = 1'b1;
        step();
        s4.start = 1'b0;
        check_val({tag, "_busy"}, 32'(s4.busy), 32'd1);
        lat = 0;
        while (!s4.done && lat < 20) begin
            step();
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'd4);
        check_val({tag, "_D"}, 32'(s4.D), 32'(exp_d));
        check_val({tag, "_borrow"}, 32'(s4.borrow), 32'(exp_br));
        step();
        check_val({tag, "_done_clr"}, 32'(s4.done), 32'd0);
    endtask

    initial begin
        int pulses;
        int lat;
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        s4.start = 1'b0;
        s4.A     = '0;
        s4.B     = '0;
        s8.start = 1'b0;
        s8.A     = '0;
        s8.B     = '0;
        #12;
        check_val("rst_busy", 32'(s4.busy), 32'd0);
        check_val("rst_done", 32'(s4.done), 32'd0);
        check_val("rst_D", 32'(s4.D), 32'd0);
        check_val("rst_borrow", 32'(s4.borrow), 32'd0);
        check_val("rst_w8_busy", 32'(s8.busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        run4("t1", 4'd9, 4'd3, 4'd6, 1'b0);
        run4("t2", 4'd3, 4'd5, EXP_3_5, 1'b1);
        run4("t3a", 4'd15, 4'd15, 4'd0, 1'b0);
        run4("t3b", 4'd0, 4'd1, EXP_0_1, 1'b1);

        // start held high through the run: only the done-cycle start is taken
        s4.A     = 4'd7;
        s4.B     = 4'd2;
        s4.start = 1'b1;
        step();
        s4.A = 4'd1;
        s4.B = 4'd1;
        check_val("t4_busy", 32'(s4.busy), 32'd1);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (s4.done) pulses++;
        end
        check_val("t4_no_early_done", 32'(pulses), 32'd0);
        check_val("t4_D_held", 32'(s4.D), 32'(EXP_0_1));
        step();
        check_val("t4_done", 32'(s4.done), 32'd1);
        check_val("t4_D", 32'(s4.D), 32'd5);
        check_val("t4_busy_low", 32'(s4.busy), 32'd0);
        step();
        s4.start = 1'b0;
        check_val("t4_same_edge_done", 32'(s4.done), 32'd0);
        check_val("t4_same_edge_busy", 32'(s4.busy), 32'd1);
        check_val("t4_D_keep", 32'(s4.D), 32'd5);
        for (int i = 0; i < 3; i++) step();
        check_val("t4b_not_yet", 32'(s4.done), 32'd0);
        step();
        check_val("t4b_done", 32'(s4.done), 32'd1);
        check_val("t4b_D", 32'(s4.D), 32'd0);
        step();

        // leave a borrow=1 result behind so the abort visibly clears it
        run4("t5pre", 4'd3, 4'd5, EXP_3_5, 1'b1);
        s4.A     = 4'd12;
        s4.B     = 4'd4;
        s4.start = 1'b1;
        step();
        s4.start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_busy", 32'(s4.busy), 32'd0);
        check_val("t5_rst_done", 32'(s4.done), 32'd0);
        check_val("t5_rst_D", 32'(s4.D), 32'd0);
        check_val("t5_rst_borrow", 32'(s4.borrow), 32'd0);
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s4.done) pulses++;
        end
        check_val("t5_no_done", 32'(pulses), 32'd0);
        run4("t5", 4'd12, 4'd4, 4'd8, 1'b0);

        s8.A     = 8'h80;
        s8.B     = 8'h01;
        s8.start = 1'b1;
        step();
        s8.start = 1'b0;
        lat = 0;
        while (!s8.done && lat < 40) begin
            step();
            lat++;
        end
        check_val("t6_lat", 32'(lat), 32'd8);
        check_val("t6_D", 32'(s8.D), 32'h7F);
        check_val("t6_borrow", 32'(s8.borrow), 32'd0);
        step();
        check_val("t6_done_clr", 32'(s8.done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
